// File: rtl/hex_msg_scheduler.sv
// hex_msg_scheduler: shares the eight-digit seven-segment display between
// two transient message sources (req/grant, round-robin, fixed hold time)
// and a live background message.
// Optional feature macro: HEX_BLINK_EN (blink held message while shown).
module hex_msg_scheduler #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int BLINK_HALF  = 12_500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_i,
    input  logic [39:0] msg0_i,
    input  logic [39:0] msg1_i,
    input  logic [39:0] bg_msg_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  done_o,
    output logic        busy_o,
    output logic [6:0]  HEX0_o,
    output logic [6:0]  HEX1_o,
    output logic [6:0]  HEX2_o,
    output logic [6:0]  HEX3_o,
    output logic [6:0]  HEX4_o,
    output logic [6:0]  HEX5_o,
    output logic [6:0]  HEX6_o,
    output logic [6:0]  HEX7_o
);

    localparam int CW = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    // Reject nonsensical parameterisations at elaboration time.
    if (HOLD_CYCLES < 2 || BLINK_HALF < 1) begin : g_param_check
        $error("hex_msg_scheduler: HOLD_CYCLES must be >= 2 and BLINK_HALF >= 1");
    end

    typedef enum logic [1:0] {IDLE, GRANT, SHOW, GAP} state_t;

    state_t          state, state_nx;
    logic            ptr;        // last-served source; also the current winner once granted
    logic            win;        // arbitration result for the request pattern seen in IDLE
    logic [CW-1:0]   cnt;
    logic [39:0]     hold_msg;
    logic [39:0]     frame_msg;
    logic [7:0][6:0] hex;
    logic [7:0][6:0] bg_seg;
    logic [7:0][6:0] show_seg;
    logic            dark_now;   // frame being loaded for SHOW is blanked

    function automatic logic [6:0] glyph(input logic [4:0] code);
        case (code)
            5'd0:    glyph = 7'b1000000;
            5'd1:    glyph = 7'b1111001;
            5'd2:    glyph = 7'b0100100;
            5'd3:    glyph = 7'b0110000;
            5'd4:    glyph = 7'b0011001;
            5'd5:    glyph = 7'b0010010;
            5'd6:    glyph = 7'b0000010;
            5'd7:    glyph = 7'b1011000;
            5'd8:    glyph = 7'b0000000;
            5'd9:    glyph = 7'b0010000;
            5'd10:   glyph = 7'b0001000;
            5'd11:   glyph = 7'b0000011;
            5'd12:   glyph = 7'b1000110;
            5'd13:   glyph = 7'b0100001;
            5'd14:   glyph = 7'b0000110;
            5'd15:   glyph = 7'b0001110;
            5'd17:   glyph = 7'b0001100;
            5'd18:   glyph = 7'b1000001;
            5'd19:   glyph = 7'b0111111;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    // Round-robin pick: a lone requester wins, on contention the source not last served.
    always_comb begin
        win = ~ptr;
        case (req_i)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            default: win = ~ptr;
        endcase
    end

    // Next-state logic plus Moore grant/done decode.
    always_comb begin
        state_nx = state;
        gnt_o    = 2'b00;
        done_o   = 2'b00;
        case (state)
            IDLE:  if (|req_i) state_nx = GRANT;
            GRANT: begin
                gnt_o    = ptr ? 2'b10 : 2'b01;
                state_nx = req_i[ptr] ? SHOW : GAP;
            end
            SHOW: begin
                gnt_o = ptr ? 2'b10 : 2'b01;
                // Normal end takes precedence over a withdrawal in the same cycle.
                if (cnt == LAST) begin
                    done_o   = ptr ? 2'b10 : 2'b01;
                    state_nx = GAP;
                end else if (!req_i[ptr]) begin
                    state_nx = GAP;
                end
            end
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, pointer, hold counter and message latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b1;
            cnt      <= '0;
            hold_msg <= '0;
            busy_o   <= 1'b0;
        end else begin
            state  <= state_nx;
            busy_o <= (state_nx != IDLE);
            if (state == IDLE && state_nx == GRANT) ptr <= win;
            if (state == GRANT) begin
                hold_msg <= ptr ? msg1_i : msg0_i;
                cnt      <= '0;
            end else if (state == SHOW) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // The first SHOW frame is loaded while the hold register is still being latched.
    always_comb frame_msg = (state == GRANT) ? (ptr ? msg1_i : msg0_i) : hold_msg;

    // Decode the background and the held/granted message, digit by digit.
    always_comb begin
        bg_seg   = '1;
        show_seg = '1;
        for (int d = 0; d < 8; d++) begin
            bg_seg[d]   = glyph(bg_msg_i[d*5 +: 5]);
            show_seg[d] = dark_now ? 7'b1111111 : glyph(frame_msg[d*5 +: 5]);
        end
    end

`ifdef HEX_BLINK_EN
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [BW-1:0] BH_C = BW'(BLINK_HALF);

    logic [BW-1:0] blk_cnt;    // SHOW frames already emitted in the current phase
    logic          blk_dark;   // phase of the most recently loaded SHOW frame

    // Entry into SHOW always starts visible; phase flips after BLINK_HALF frames.
    always_comb dark_now = (state == GRANT) ? 1'b0 : ((blk_cnt == BH_C) ? ~blk_dark : blk_dark);

    // Blink phase tracking, cleared on every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt  <= '0;
            blk_dark <= 1'b0;
        end else if (state_nx == SHOW) begin
            blk_dark <= dark_now;
            blk_cnt  <= (state == GRANT || blk_cnt == BH_C) ? BW'(1) : blk_cnt + BW'(1);
        end else if (state == GRANT) begin
            blk_cnt  <= '0;
            blk_dark <= 1'b0;
        end
    end
`else
    assign dark_now = 1'b0;
`endif

    // Display register: live background in IDLE/GRANT, held frame in SHOW, frozen in GAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            hex <= '1;
        end else begin
            case (state_nx)
                IDLE, GRANT: hex <= bg_seg;
                SHOW:        hex <= show_seg;
                default:     hex <= hex;
            endcase
        end
    end

    assign HEX0_o = hex[0];
    assign HEX1_o = hex[1];
    assign HEX2_o = hex[2];
    assign HEX3_o = hex[3];
    assign HEX4_o = hex[4];
    assign HEX5_o = hex[5];
    assign HEX6_o = hex[6];
    assign HEX7_o = hex[7];

endmodule

// File: tb/tb_hex_msg_scheduler.sv
// Self-checking bench for hex_msg_scheduler (HOLD_CYCLES=4, BLINK_HALF=2).
// Expected behaviour comes from a transaction-level model: glyph table,
// last-served arbitration variable and the grant timeline as arithmetic.
module tb_hex_msg_scheduler;

    localparam int HOLD = 4;
    localparam int BH   = 2;
`ifdef HEX_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    localparam logic [6:0] SEG [32] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
        7'b0000010, 7'b1011000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110, 7'b1111111, 7'b0001100,
        7'b1000001, 7'b0111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111,
        7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111,
        7'b1111111, 7'b1111111};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [39:0] m0 = '0, m1 = '0, bg = '0;
    logic [1:0]  gnt_o, done_o;
    logic        busy_o;
    logic [6:0]  HEX0_o, HEX1_o, HEX2_o, HEX3_o, HEX4_o, HEX5_o, HEX6_o, HEX7_o;
    logic [55:0] hex_all;

    int n_chk = 0;
    int n_fail = 0;
    int last_served = 1;

    hex_msg_scheduler #(.HOLD_CYCLES(HOLD), .BLINK_HALF(BH)) dut (
        .clk(clk), .rst(rst), .req_i(req), .msg0_i(m0), .msg1_i(m1), .bg_msg_i(bg),
        .gnt_o(gnt_o), .done_o(done_o), .busy_o(busy_o),
        .HEX0_o(HEX0_o), .HEX1_o(HEX1_o), .HEX2_o(HEX2_o), .HEX3_o(HEX3_o),
        .HEX4_o(HEX4_o), .HEX5_o(HEX5_o), .HEX6_o(HEX6_o), .HEX7_o(HEX7_o));

    assign hex_all = {HEX7_o, HEX6_o, HEX5_o, HEX4_o, HEX3_o, HEX2_o, HEX1_o, HEX0_o};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [55:0] frame(input logic [39:0] m);
        logic [55:0] f;
        for (int d = 0; d < 8; d++) f[d*7 +: 7] = SEG[m[d*5 +: 5]];
        return f;
    endfunction

    // SHOW frame j (0-based): dark during odd blink half-periods when blinking.
    function automatic logic [55:0] show_frame(input logic [39:0] m, input int j);
        if (BLINK && ((j / BH) % 2) == 1) return '1;
        return frame(m);
    endfunction

    function automatic logic [39:0] rand_msg();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[39:0];
    endfunction

    function automatic int exp_winner(input logic [1:0] r);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        return (last_served == 0) ? 1 : 0;
    endfunction

    // One complete grant: GRANT, SHOW (optionally withdrawn after SHOW cycle wd), GAP, IDLE.
    task automatic run_grant(input int src, input int wd, input logic [1:0] req_after);
        logic [1:0]  oh;
        logic [1:0]  exp_done;
        logic [39:0] held;
        logic [55:0] last_f;
        oh = (src == 1) ? 2'b10 : 2'b01;
        step();
        n_chk++;
        if ({gnt_o, done_o, busy_o} !== {oh, 2'b00, 1'b1}) begin
            n_fail++;
            $display("FAIL grant_ctrl: gnt/done/busy got %b/%b/%b expected %b/00/1", gnt_o, done_o, busy_o, oh);
        end
        n_chk++;
        if (hex_all !== frame(bg)) begin
            n_fail++;
            $display("FAIL grant_hex: got %h expected %h", hex_all, frame(bg));
        end
        held = (src == 1) ? m1 : m0;
        last_served = src;
        last_f = frame(bg);
        for (int j = 0; j < HOLD; j++) begin
            step();
            exp_done = (j == HOLD - 1) ? oh : 2'b00;
            n_chk++;
            if ({gnt_o, done_o, busy_o} !== {oh, exp_done, 1'b1}) begin
                n_fail++;
                $display("FAIL show%0d_ctrl: gnt/done/busy got %b/%b/%b expected %b/%b/1", j, gnt_o, done_o, busy_o, oh, exp_done);
            end
            last_f = show_frame(held, j);
            n_chk++;
            if (hex_all !== last_f) begin
                n_fail++;
                $display("FAIL show%0d_hex: got %h expected %h", j, hex_all, last_f);
            end
            // New source messages mid-grant must not reach the display.
            m0 = rand_msg();
            m1 = rand_msg();
            if (j == wd) begin
                req[src] = 1'b0;
                break;
            end
        end
        step();
        n_chk++;
        if ({gnt_o, done_o, busy_o} !== 5'b00001) begin
            n_fail++;
            $display("FAIL gap_ctrl: gnt/done/busy got %b/%b/%b expected 00/00/1", gnt_o, done_o, busy_o);
        end
        n_chk++;
        if (hex_all !== last_f) begin
            n_fail++;
            $display("FAIL gap_hex: got %h expected %h", hex_all, last_f);
        end
        req = req_after;
        step();
        n_chk++;
        if ({gnt_o, done_o, busy_o} !== 5'b00000) begin
            n_fail++;
            $display("FAIL idle_ctrl: gnt/done/busy got %b/%b/%b expected 00/00/0", gnt_o, done_o, busy_o);
        end
        n_chk++;
        if (hex_all !== frame(bg)) begin
            n_fail++;
            $display("FAIL idle_hex: got %h expected %h", hex_all, frame(bg));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bg  = {{7{5'd16}}, 5'd7};
        step();
        n_chk++;
        if (hex_all !== '1) begin
            n_fail++;
            $display("FAIL reset_hex: got %h expected all ones", hex_all);
        end
        n_chk++;
        if ({gnt_o, done_o, busy_o} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_ctrl: gnt/done/busy got %b/%b/%b expected 00/00/0", gnt_o, done_o, busy_o);
        end
        rst = 1'b0;
        last_served = 1;
        step();
        n_chk++;
        if (HEX0_o !== 7'b1011000) begin
            n_fail++;
            $display("FAIL reset_bg_hex0: got %b expected 1011000", HEX0_o);
        end
        n_chk++;
        if (hex_all[55:7] !== '1) begin
            n_fail++;
            $display("FAIL reset_bg_dark: got %h expected all ones", hex_all[55:7]);
        end
    endtask

    task automatic test_background();
        for (int i = 0; i < 6; i++) begin
            bg = rand_msg();
            step();
            n_chk++;
            if (hex_all !== frame(bg) || busy_o !== 1'b0 || gnt_o !== 2'b00) begin
                n_fail++;
                $display("FAIL bg_live%0d: hex %h busy %b gnt %b expected hex %h busy 0 gnt 00", i, hex_all, busy_o, gnt_o, frame(bg));
            end
        end
    endtask

    task automatic test_single();
        m0  = {8{5'd17}};
        req = 2'b01;
        run_grant(exp_winner(req), -1, 2'b00);
        m1  = rand_msg();
        req = 2'b10;
        run_grant(exp_winner(req), -1, 2'b00);
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_served = 1;
        bg  = rand_msg();
        m0  = rand_msg();
        m1  = rand_msg();
        req = 2'b11;
        for (int i = 0; i < 3; i++) run_grant(exp_winner(2'b11), -1, (i == 2) ? 2'b00 : 2'b11);
    endtask

    task automatic test_withdraw();
        req = 2'b11;
        run_grant(exp_winner(req), 1, 2'b00);
    endtask

    task automatic test_random();
        logic [1:0] r;
        int wd;
        for (int i = 0; i < 10; i++) begin
            r   = 2'($urandom_range(1, 3));
            wd  = int'($urandom_range(0, HOLD)) - 1;
            if (wd == HOLD - 1) wd = -1;
            bg  = rand_msg();
            m0  = rand_msg();
            m1  = rand_msg();
            req = r;
            run_grant(exp_winner(r), wd, 2'b00);
        end
    endtask

    task automatic test_reset_mid();
        req = 2'b01;
        step();
        step();
        step();
        n_chk++;
        if (gnt_o !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_pre_gnt: got %b expected 01", gnt_o);
        end
        req = 2'b11;
        rst = 1'b1;
        step();
        n_chk++;
        if (hex_all !== '1 || {gnt_o, done_o, busy_o} !== 5'b00000) begin
            n_fail++;
            $display("FAIL midrst_abort: hex %h gnt/done/busy %b/%b/%b expected all ones 00/00/0", hex_all, gnt_o, done_o, busy_o);
        end
        rst = 1'b0;
        last_served = 1;
        run_grant(exp_winner(req), -1, 2'b00);
    endtask

    initial begin
        test_reset();
        test_background();
        test_single();
        test_round_robin();
        test_withdraw();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
